// File: rtl/if_fetch_unit.sv
// Instruction-fetch initiator: owns the PC, issues instruction-memory reads, yields the SRAM
// to the data stage and feeds the IF/ID register with stall, bubble and branch handling.
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [7:0]  MAX_WAIT  = 8'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_conflict,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ack,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus1,
    output logic        if_valid,
    output logic        fetch_timeout
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] hold_instr;
    logic [15:0] hold_pc;
    logic [7:0]  wait_cnt;

    logic        ack;
    logic [15:0] pc_inc;
    logic [7:0]  wait_cnt_inc;

    // An ack only completes a request that is actually on the bus.
    assign ack          = imem_req & imem_ack;
    assign pc_inc       = pc + 16'd1;
    assign wait_cnt_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_FETCH;
            pc            <= RESET_PC;
            imem_req      <= 1'b0;
            imem_addr     <= RESET_PC;
            if_instr      <= NOP_INSTR;
            if_pc         <= 16'h0000;
            if_pc_plus1   <= 16'h0001;
            if_valid      <= 1'b0;
            hold_instr    <= NOP_INSTR;
            hold_pc       <= 16'h0000;
            wait_cnt      <= 8'd0;
            fetch_timeout <= 1'b0;
        end else if (branch_taken) begin
            // Redirect wins over everything: drop in-flight data, flush IF/ID, refetch next cycle.
            state      <= S_FETCH;
            pc         <= branch_target;
            imem_req   <= 1'b0;
            if_instr   <= NOP_INSTR;
            if_valid   <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_pc    <= 16'h0000;
            wait_cnt   <= 8'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    wait_cnt <= 8'd0;
                    if (!stall) begin
                        if_instr <= NOP_INSTR;
                        if_valid <= 1'b0;
                    end
                    if (!mem_conflict) begin
                        state     <= S_WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end

                S_WAIT: begin
                    if (ack) begin
                        wait_cnt <= 8'd0;
                        pc       <= pc_inc;
                        if (!stall) begin
                            if_instr    <= imem_rdata;
                            if_pc       <= pc;
                            if_pc_plus1 <= pc_inc;
                            if_valid    <= 1'b1;
                            if (!mem_conflict) begin
                                imem_addr <= pc_inc;
                            end else begin
                                state    <= S_FETCH;
                                imem_req <= 1'b0;
                            end
                        end else begin
                            state      <= S_HOLD;
                            imem_req   <= 1'b0;
                            hold_instr <= imem_rdata;
                            hold_pc    <= pc;
                        end
                    end else begin
                        if (!stall) begin
                            if_instr <= NOP_INSTR;
                            if_valid <= 1'b0;
                        end
                        if (mem_conflict) begin
                            // Abandon the request; pc is untouched so the same word is retried.
                            state    <= S_FETCH;
                            imem_req <= 1'b0;
                            wait_cnt <= 8'd0;
                        end else begin
                            wait_cnt <= wait_cnt_inc;
                            if (wait_cnt_inc >= MAX_WAIT) begin
                                fetch_timeout <= 1'b1;
                            end
                        end
                    end
                end

                S_HOLD: begin
                    wait_cnt <= 8'd0;
                    if (!stall) begin
                        if_instr    <= hold_instr;
                        if_pc       <= hold_pc;
                        if_pc_plus1 <= hold_pc + 16'd1;
                        if_valid    <= 1'b1;
                        if (!mem_conflict) begin
                            state     <= S_WAIT;
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end

                default: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch initiator for the 16-bit ThinPad pipeline. It owns the PC and issues read requests to the instruction memory port. It yields the shared SRAM whenever the data stage raises a memory conflict, and delivers fetched words into the IF/ID register with valid, stall, bubble and branch-redirect handling. A wait-timeout monitor flags a memory that never acknowledges.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset
NOP_INSTR, 16'h0800, bubble word written to IF/ID
MAX_WAIT, 8'd15, cycles in WAIT without ack before fetch_timeout sets

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
mem_conflict  input  1  data stage owns SRAM this cycle; fetch must not request
stall  input  1  hazard unit holds IF/ID and PC
branch_taken  input  1  redirect PC; flush in-flight fetch and IF/ID
branch_target  input  16  redirect address
imem_req  output  1  read request, registered
imem_addr  output  16  read address, registered, stable while imem_req=1
imem_rdata  input  16  instruction word, valid when imem_ack=1
imem_ack  input  1  memory completes the current request this cycle
if_instr  output  16  IF/ID instruction
if_pc  output  16  address of if_instr
if_pc_plus1  output  16  if_pc+1 (mod 2^16)
if_valid  output  1  if_instr is a real fetched word
fetch_timeout  output  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=FETCH, imem_req=0, imem_addr=RESET_PC, if_instr=NOP_INSTR, if_pc=0, if_pc_plus1=1, if_valid=0, hold buffer empty, wait_cnt=0, fetch_timeout=0.
- States: FETCH (no request outstanding), WAIT (imem_req=1, awaiting ack), HOLD (word captured, IF/ID stalled).
- An ack counts only when imem_req=1 and imem_ack=1. An ack may arrive in the first cycle of WAIT.
- FETCH:
  - If mem_conflict=0, go to WAIT with imem_req<=1 and imem_addr<=pc.
  - If mem_conflict=1, stay in FETCH with imem_req=0.
- WAIT, ack received, stall=0:
  - Write imem_rdata to IF/ID: if_instr<=imem_rdata, if_pc<=pc, if_pc_plus1<=pc+1, if_valid<=1.
  - pc<=pc+1.
  - If mem_conflict=0, stay in WAIT with imem_addr<=pc+1. This is the back-to-back path: 1 instruction/cycle with zero-wait memory.
  - If mem_conflict=1, go to FETCH with imem_req<=0.
- WAIT, ack received, stall=1:
  - Capture the word and its pc into the hold buffer; pc<=pc+1.
  - imem_req<=0, go to HOLD.
  - IF/ID is unchanged.
- WAIT, no ack:
  - If mem_conflict=1, abort the request: imem_req<=0, go to FETCH, retry the same pc. The memory must tolerate an unacknowledged req drop.
  - Otherwise stay in WAIT.
- HOLD: when stall=0, move the hold buffer to IF/ID with if_valid=1. Go to WAIT at the new pc if mem_conflict=0, else go to FETCH.
- IF/ID when no word is delivered in a cycle:
  - stall=1: IF/ID holds.
  - stall=0: bubble, i.e. if_instr<=NOP_INSTR and if_valid<=0; if_pc and if_pc_plus1 hold.
- branch_taken=1 has highest priority, overriding stall, ack and mem_conflict:
  - pc<=branch_target.
  - Any same-cycle ack data is discarded; the hold buffer is cleared.
  - imem_req<=0, state<=FETCH.
  - IF/ID is flushed to NOP_INSTR with if_valid=0.
  - The request for branch_target is issued the following cycle, subject to mem_conflict.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1=16'h0000. The same applies to if_pc_plus1.
- Timeout:
  - wait_cnt is 8 bits, increments each cycle in WAIT without an ack, saturates at 255.
  - wait_cnt clears on ack, on leaving WAIT, and on a branch.
  - fetch_timeout<=1 when wait_cnt reaches MAX_WAIT and stays set until reset. Fetching continues unchanged.
- Reset asserted mid-request: all state returns to reset values immediately and imem_req drops asynchronously.

Test Plan:
1. Reset release, zero-wait memory (ack every req cycle, rdata=addr^16'hA5A5), no conflict/stall -> imem_req rises 1 cycle after reset; IF/ID carries pc 0,1,2,3 with if_valid=1 on consecutive cycles; if_instr=16'hA5A5,16'hA5A4,...
2. mem_conflict high for 2 cycles while in WAIT with ack withheld -> imem_req drops; two bubbles (if_instr=16'h0800, if_valid=0); request re-issued at the same pc after conflict clears; no pc skipped or duplicated.
3. stall=1 coincident with ack of pc=5 for 3 cycles -> IF/ID holds the previous word; the pc=5 word is delivered the cycle after stall drops; next request is pc=6.
4. branch_taken=1, branch_target=16'h0040, coincident with ack of pc=9 -> pc=9 data discarded; IF/ID shows NOP with if_valid=0; next imem_addr=16'h0040.
5. pc preset via branch to 16'hFFFF -> if_pc_plus1=16'h0000; next fetch address 16'h0000.
6. Ack withheld 20 cycles -> fetch_timeout=1 at the 15th waiting cycle and stays 1 after ack resumes; cleared only by rst=0; rst asserted mid-WAIT drops imem_req immediately.
